// File: rtl/shift_exec_pipe_pkg.sv
// Shared constants and op-code helpers for the shift/rotate execute unit.
package shift_exec_pipe_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned SHW_DEF   = 4;
    localparam int unsigned TAG_W_DEF = 3;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    function automatic logic op_is_left(input logic [1:0] op);
        return (op == OP_ROL) || (op == OP_SLL);
    endfunction

    function automatic logic op_is_rotate(input logic [1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_exec_pipe_shift_core.sv
// Combinational log-depth barrel shifter/rotator: one mux stage per amount bit.
module shift_core
    import shift_exec_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SHW   = SHW_DEF
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [SHW-1:0]   amt_i,
    output logic [WIDTH-1:0] res_o
);

    logic left;
    logic rot;
    logic [SHW:0][WIDTH-1:0] stage;

    assign left     = op_is_left(op_i);
    assign rot      = op_is_rotate(op_i);
    assign stage[0] = a_i;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned Sh = 1 << k;

        logic [Sh-1:0]    wrap_l;
        logic [Sh-1:0]    wrap_r;
        logic [WIDTH-1:0] shl;
        logic [WIDTH-1:0] shr;

        // Bits pushed off one end re-enter at the other for rotates, zeros otherwise.
        assign wrap_l = rot ? stage[k][WIDTH-1 -: Sh] : '0;
        assign wrap_r = rot ? stage[k][Sh-1:0] : '0;
        assign shl    = {stage[k][WIDTH-1-Sh:0], wrap_l};
        assign shr    = {wrap_r, stage[k][WIDTH-1:Sh]};

        assign stage[k+1] = amt_i[k] ? (left ? shl : shr) : stage[k];
    end

    assign res_o = stage[SHW];

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage elastic execute pipe for ROL/SLL/ROR/SRL with flush and backpressure.
module shift_exec_pipe
    import shift_exec_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SHW   = SHW_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [SHW-1:0]   s1_amt_q, s1_amt_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] core_res;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready && !flush;

    shift_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift_core (
        .op_i  (s1_op_q),
        .a_i   (s1_a_q),
        .amt_i (s1_amt_q),
        .res_o (core_res)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_amt_d   = s1_amt_q;
        s1_tag_d   = s1_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            // Covers the refill case where S1 hands off to S2 in the same cycle.
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_amt_d   = in_amt;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_zero_d  = s2_zero_q;
        s2_tag_d   = s2_tag_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_res_d   = core_res;
            s2_zero_d  = (core_res == '0);
            s2_tag_d   = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_amt_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zero_q  <= 1'b1;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_amt_q   <= s1_amt_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_zero_q  <= s2_zero_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_zero  = s2_zero_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: directed scenarios plus a randomized model run.
module tb_shift_exec_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [3:0]  in_amt;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_zero;
    logic [2:0]  out_tag;

    int n_vec;
    int n_err;

    shift_exec_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-arithmetic reference: rotates are two shifts OR-ed then truncated.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] a,
                                              input logic [3:0] amt);
        int unsigned x;
        int unsigned n;
        int unsigned r;
        x = a;
        n = amt;
        case (op)
            2'b00:   r = (x << n) | (x >> (16 - n));
            2'b01:   r = x << n;
            2'b10:   r = (x >> n) | (x << (16 - n));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [13] = '{
        '{2'b00, 16'h8001, 4'd1,  16'h0003},
        '{2'b01, 16'h8001, 4'd4,  16'h0010},
        '{2'b10, 16'h0001, 4'd1,  16'h8000},
        '{2'b11, 16'h8000, 4'd15, 16'h0001},
        '{2'b11, 16'h0001, 4'd1,  16'h0000},
        '{2'b00, 16'hA5C3, 4'd0,  16'hA5C3},
        '{2'b01, 16'hA5C3, 4'd0,  16'hA5C3},
        '{2'b10, 16'hA5C3, 4'd0,  16'hA5C3},
        '{2'b11, 16'hA5C3, 4'd0,  16'hA5C3},
        '{2'b01, 16'h8001, 4'd15, 16'h8000},
        '{2'b10, 16'h8001, 4'd15, 16'h0003},
        '{2'b00, 16'h1234, 4'd8,  16'h3412},
        '{2'b11, 16'hF0F0, 4'd4,  16'h0F0F}
    };

    typedef struct {
        logic [15:0] res;
        logic [2:0]  tag;
        int          age;
    } exp_t;

    task automatic drive_op(input logic [1:0] op, input logic [15:0] a, input logic [3:0] amt,
                            input logic [2:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_amt   = amt;
        in_tag   = tag;
    endtask

    task automatic idle_drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_res !== 16'h0 || out_zero !== 1'b1 || out_tag !== 3'd0
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got v=%b res=%h z=%b tag=%0d rdy=%b want v=0 res=0000 z=1 tag=0 rdy=1",
                     out_valid, out_res, out_zero, out_tag, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive_op(tbl[i].op, tbl[i].a, tbl[i].amt, 3'(i));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL arith_latency1[%0d]: got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_res !== tbl[i].exp || out_zero !== (tbl[i].exp == 16'h0)
                || out_tag !== 3'(i)) begin
                n_err++;
                $display("FAIL arith[%0d]: got v=%b res=%h z=%b tag=%0d want v=1 res=%h z=%b tag=%0d",
                         i, out_valid, out_res, out_zero, out_tag, tbl[i].exp,
                         (tbl[i].exp == 16'h0), i);
            end
        end
        idle_drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_res [8];
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                logic [15:0] a;
                logic [3:0]  amt;
                logic [1:0]  op;
                a   = 16'($urandom);
                amt = 4'($urandom);
                op  = 2'($urandom);
                exp_res[cyc] = ref_shift(op, a, amt);
                drive_op(op, a, amt, 3'(cyc));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 8) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready[%0d]: got in_ready=%b want 1", cyc, in_ready);
                end
            end
            n_vec++;
            if (cyc < 2) begin
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_early[%0d]: got out_valid=%b want 0", cyc, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_tag !== 3'(cyc - 2)
                         || out_res !== exp_res[cyc-2]) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: got v=%b tag=%0d res=%h want v=1 tag=%0d res=%h",
                         cyc, out_valid, out_tag, out_res, cyc - 2, exp_res[cyc-2]);
            end
        end
        idle_drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] r1, r2, r3;
        r1 = ref_shift(2'b00, 16'h1357, 4'd3);
        r2 = ref_shift(2'b11, 16'hBEEF, 4'd5);
        r3 = ref_shift(2'b01, 16'h0F0F, 4'd7);
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(2'b00, 16'h1357, 4'd3, 3'd1);
        @(negedge clk);
        drive_op(2'b11, 16'hBEEF, 4'd5, 3'd2);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_second: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(2'b01, 16'h0F0F, 4'd7, 3'd3);
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 3'd1 || out_res !== r1) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got rdy=%b v=%b tag=%0d res=%h want rdy=0 v=1 tag=1 res=%h",
                         i, in_ready, out_valid, out_tag, out_res, r1);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_tag !== 3'd1 || out_res !== r1) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b tag=%0d res=%h want rdy=1 tag=1 res=%h",
                     in_ready, out_tag, out_res, r1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_tag !== 3'd2 || out_res !== r2) begin
            n_err++;
            $display("FAIL bp_tag2: got v=%b tag=%0d res=%h want v=1 tag=2 res=%h",
                     out_valid, out_tag, out_res, r2);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_tag !== 3'd3 || out_res !== r3) begin
            n_err++;
            $display("FAIL bp_tag3: got v=%b tag=%0d res=%h want v=1 tag=3 res=%h",
                     out_valid, out_tag, out_res, r3);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
        end
        idle_drain();
    endtask

    task automatic test_flush();
        logic [15:0] r5;
        r5 = ref_shift(2'b10, 16'hC001, 4'd2);
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(2'b00, 16'h1111, 4'd1, 3'd1);
        @(negedge clk);
        drive_op(2'b00, 16'h2222, 4'd1, 3'd2);
        @(negedge clk);
        flush = 1'b1;
        drive_op(2'b01, 16'h4444, 4'd1, 3'd4);
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive_op(2'b10, 16'hC001, 4'd2, 3'd5);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_kill: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_discard: got out_valid=%b tag=%0d want 0", out_valid, out_tag);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_tag !== 3'd5 || out_res !== r5) begin
            n_err++;
            $display("FAIL flush_next: got v=%b tag=%0d res=%h want v=1 tag=5 res=%h",
                     out_valid, out_tag, out_res, r5);
        end
        idle_drain();
    endtask

    task automatic test_async_reset();
        logic [15:0] r6;
        r6 = ref_shift(2'b11, 16'h8421, 4'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(2'b00, 16'h00FF + 16'(i), 4'(i + 1), 3'(i));
        end
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_res !== 16'h0 || out_zero !== 1'b1 || out_tag !== 3'd0) begin
            n_err++;
            $display("FAIL async_rst: got v=%b res=%h z=%b tag=%0d want v=0 res=0000 z=1 tag=0",
                     out_valid, out_res, out_zero, out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_op(2'b11, 16'h8421, 4'd3, 3'd6);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_lat1: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_tag !== 3'd6 || out_res !== r6) begin
            n_err++;
            $display("FAIL rst_lat2: got v=%b tag=%0d res=%h want v=1 tag=6 res=%h",
                     out_valid, out_tag, out_res, r6);
        end
        idle_drain();
    endtask

    // Transaction model: FIFO of capacity two, an entry is visible once one edge past its accept.
    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic exp_rdy, exp_ov, do_pop, do_acc;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            in_op     = 2'($urandom);
            in_a      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            in_amt    = 4'($urandom);
            in_tag    = 3'(cyc);
            #1;
            exp_rdy = (q.size() < 2) || out_ready;
            exp_ov  = (q.size() > 0) && (q[0].age >= 1);
            n_vec++;
            if (in_ready !== exp_rdy || out_valid !== exp_ov) begin
                n_err++;
                $display("FAIL rand_hs[%0d]: got rdy=%b v=%b want rdy=%b v=%b",
                         cyc, in_ready, out_valid, exp_rdy, exp_ov);
            end
            if (exp_ov) begin
                n_vec++;
                if (out_res !== q[0].res || out_tag !== q[0].tag
                    || out_zero !== (q[0].res == 16'h0)) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got res=%h z=%b tag=%0d want res=%h z=%b tag=%0d",
                             cyc, out_res, out_zero, out_tag, q[0].res, (q[0].res == 16'h0),
                             q[0].tag);
                end
            end
            do_pop = exp_ov && out_ready;
            do_acc = in_valid && exp_rdy && !flush;
            e.res  = ref_shift(in_op, in_a, in_amt);
            e.tag  = in_tag;
            e.age  = 0;
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) q[i].age++;
                if (do_acc) q.push_back(e);
            end
        end
        idle_drain();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 16'h0;
        in_amt    = 4'd0;
        in_tag    = 3'd0;
        out_ready = 1'b1;
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion want finish before 1000000");
        $fatal(1);
    end

endmodule
